// File: rtl/joint_ctrl_pkg.sv
// Shared types and helpers for the joint position controller.
package joint_ctrl_pkg;

  // Auto-repeat sequencer states.
  typedef enum logic [1:0] {
    IDLE,
    HOLD,
    REPEAT,
    WAIT_REL
  } ar_state_t;

  // Default servo travel limits, in position units.
  localparam int DEF_POS_MIN  = 0;
  localparam int DEF_POS_MAX  = 180;
  localparam int DEF_POS_INIT = 90;

  // Step a position up or down by delta and clamp it into [lo, hi].
  // The sum is formed in 32 bits, which is wider than any position
  // register, so stepping past either end never wraps before the clamp.
  function automatic int sat_step(input int cur, input int delta,
                                  input logic up, input int lo, input int hi);
    int nxt;
    nxt = up ? cur + delta : cur - delta;
    if (nxt > hi) begin
      nxt = hi;
    end else if (nxt < lo) begin
      nxt = lo;
    end
    return nxt;
  endfunction

endpackage

// File: rtl/btn_autorepeat.sv
// Press / hold / auto-repeat sequencer. Turns a held direction into a first
// step, a step after HOLD_TICKS ticks, then a step every RPT_TICKS ticks.
module btn_autorepeat
  import joint_ctrl_pkg::*;
#(
  parameter int HOLD_TICKS = 25,
  parameter int RPT_TICKS  = 5
) (
  input  logic clk,
  input  logic rst,
  input  logic tick,
  input  logic dir_up,
  input  logic dir_dn,
  input  logic any_held,
  input  logic btn_next,
  output logic step_up,
  output logic step_dn
);

  localparam int CNT_MAX = (HOLD_TICKS > RPT_TICKS) ? HOLD_TICKS : RPT_TICKS;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);
  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_TICKS - 1);
  localparam logic [CNT_W-1:0] RPT_LAST  = CNT_W'(RPT_TICKS - 1);

  ar_state_t        state, state_nx;
  logic [CNT_W-1:0] cnt, cnt_nx;
  logic             last_up, last_up_nx;
  logic             same_dir;
  logic [CNT_W-1:0] cnt_last;

  // Still holding the direction that started this press (both-held is none).
  assign same_dir = last_up ? dir_up : dir_dn;
  assign cnt_last = (state == HOLD) ? HOLD_LAST : RPT_LAST;

  // State, tick counter and latched press direction.
  // NOTE: clocked state uses non-blocking (<=) so every register samples
  // pre-edge values; blocking here would create order-dependent races.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= IDLE;
      cnt     <= '0;
      last_up <= 1'b0;
    end else begin
      state   <= state_nx;
      cnt     <= cnt_nx;
      last_up <= last_up_nx;
    end
  end

  // Next-state and step-strobe decode.
  // NOTE: every output of this block gets a default first so no path
  // leaves one unassigned, which would otherwise infer a latch.
  always_comb begin
    state_nx   = state;
    cnt_nx     = cnt;
    last_up_nx = last_up;
    step_up    = 1'b0;
    step_dn    = 1'b0;
    unique case (state)
      IDLE: begin
        if (dir_up || dir_dn) begin
          step_up    = dir_up;
          step_dn    = dir_dn;
          last_up_nx = dir_up;
          cnt_nx     = '0;
          state_nx   = HOLD;
        end
      end
      HOLD, REPEAT: begin
        if (!same_dir) begin
          // Released, both held, or reversed: the next cycle starts fresh.
          cnt_nx   = '0;
          state_nx = IDLE;
        end else if (btn_next) begin
          cnt_nx   = '0;
          state_nx = WAIT_REL;
        end else if (tick) begin
          if (cnt == cnt_last) begin
            step_up  = last_up;
            step_dn  = !last_up;
            cnt_nx   = '0;
            state_nx = REPEAT;
          end else begin
            cnt_nx = cnt + CNT_W'(1);
          end
        end
      end
      WAIT_REL: begin
        // A press that outlives a joint change must not carry over to it.
        if (!any_held) begin
          state_nx = IDLE;
        end
      end
      default: begin
        state_nx = IDLE;
      end
    endcase
  end

endmodule

// File: rtl/joint_position_ctrl.sv
// Push-button joint selector and position setpoint register file for the
// arm's servo PWM channels.
module joint_position_ctrl
  import joint_ctrl_pkg::*;
#(
  parameter int NUM_JOINTS = 4,
  parameter int POS_W      = 8,
  parameter int POS_MIN    = DEF_POS_MIN,
  parameter int POS_MAX    = DEF_POS_MAX,
  parameter int POS_INIT   = DEF_POS_INIT,
  parameter int STEP       = 1,
  parameter int HOLD_TICKS = 25,
  parameter int RPT_TICKS  = 5
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          tick,
  input  logic                          btn_up,
  input  logic                          btn_dn,
  input  logic                          btn_next,
  output logic [$clog2(NUM_JOINTS)-1:0] sel,
  output logic [NUM_JOINTS*POS_W-1:0]   pos_flat,
  output logic                          upd,
  output logic                          at_limit
);

  localparam int SEL_W = $clog2(NUM_JOINTS);
  localparam logic [SEL_W-1:0] SEL_LAST = SEL_W'(NUM_JOINTS - 1);
  localparam logic [POS_W-1:0] MIN_V    = POS_W'(POS_MIN);
  localparam logic [POS_W-1:0] MAX_V    = POS_W'(POS_MAX);
  localparam logic [POS_W-1:0] INIT_V   = POS_W'(POS_INIT);

  logic [POS_W-1:0] pos [NUM_JOINTS];
  logic [POS_W-1:0] pos_cur, pos_nx;
  logic             dir_up, dir_dn, any_held;
  logic             step_up, step_dn;

  // Opposing buttons cancel out.
  assign dir_up   = btn_up & ~btn_dn;
  assign dir_dn   = btn_dn & ~btn_up;
  assign any_held = btn_up | btn_dn;

  btn_autorepeat #(
    .HOLD_TICKS (HOLD_TICKS),
    .RPT_TICKS  (RPT_TICKS)
  ) u_autorepeat (
    .clk      (clk),
    .rst      (rst),
    .tick     (tick),
    .dir_up   (dir_up),
    .dir_dn   (dir_dn),
    .any_held (any_held),
    .btn_next (btn_next),
    .step_up  (step_up),
    .step_dn  (step_dn)
  );

  // Selected joint's current value and its saturated stepped value.
  always_comb begin
    pos_cur = pos[sel];
    pos_nx  = POS_W'(sat_step(int'(pos_cur), STEP, step_up, POS_MIN, POS_MAX));
  end

  // Position registers, joint selection and change strobe.
  // NOTE: the position array is reset in full because each joint must come
  // up at a known servo setpoint; a storage array with no such need would
  // be left unreset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sel <= '0;
      upd <= 1'b0;
      for (int i = 0; i < NUM_JOINTS; i++) begin
        pos[i] <= INIT_V;
      end
    end else begin
      upd <= 1'b0;
      // The step lands on the joint selected now, before any advance.
      if (step_up || step_dn) begin
        pos[sel] <= pos_nx;
        upd      <= (pos_nx != pos_cur);
      end
      if (btn_next) begin
        sel <= (sel == SEL_LAST) ? '0 : sel + SEL_W'(1);
      end
    end
  end

  // Flatten the register file for the PWM duty generators.
  for (genvar g = 0; g < NUM_JOINTS; g++) begin : g_flat
    assign pos_flat[g*POS_W +: POS_W] = pos[g];
  end

  assign at_limit = (pos_cur == MIN_V) || (pos_cur == MAX_V);

endmodule

// File: tb/tb_joint_position_ctrl.sv
// Self-checking bench for joint_position_ctrl: a reference model predicts
// every position change, queues the expected pos_flat, and a monitor pops
// and compares an entry on each upd strobe.
module tb_joint_position_ctrl;

  localparam int NJ    = 4;
  localparam int PW    = 8;
  localparam int P_MAX = 180;
  localparam int P_MIN = 0;
  localparam int P_INI = 90;

  logic              clk = 1'b0;
  logic              rst;
  logic              tick, btn_up, btn_dn, btn_next;
  logic [1:0]        sel;
  logic [NJ*PW-1:0]  pos_flat;
  logic              upd, at_limit;

  int n_checks = 0;
  int n_errors = 0;

  int                exp_pos [NJ];
  int                exp_sel;
  logic [NJ*PW-1:0]  exp_q [$];

  joint_position_ctrl dut (
    .clk      (clk),
    .rst      (rst),
    .tick     (tick),
    .btn_up   (btn_up),
    .btn_dn   (btn_dn),
    .btn_next (btn_next),
    .sel      (sel),
    .pos_flat (pos_flat),
    .upd      (upd),
    .at_limit (at_limit)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [NJ*PW-1:0] model_flat();
    logic [NJ*PW-1:0] f;
    for (int i = 0; i < NJ; i++) f[i*PW +: PW] = PW'(exp_pos[i]);
    return f;
  endfunction

  // Predict one step on the model's selected joint; queue it if it changes.
  task automatic model_step(input bit up);
    int n;
    n = up ? exp_pos[exp_sel] + 1 : exp_pos[exp_sel] - 1;
    if (n > P_MAX) n = P_MAX;
    if (n < P_MIN) n = P_MIN;
    if (n != exp_pos[exp_sel]) begin
      exp_pos[exp_sel] = n;
      exp_q.push_back(model_flat());
    end
  endtask

  task automatic model_next();
    exp_sel = (exp_sel == NJ - 1) ? 0 : exp_sel + 1;
  endtask

  task automatic model_reset();
    for (int i = 0; i < NJ; i++) exp_pos[i] = P_INI;
    exp_sel = 0;
  endtask

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic tick_n(input int n);
    repeat (n) begin
      tick = 1'b1; cyc(1);
      tick = 1'b0; cyc(1);
    end
  endtask

  // Every upd strobe must match the oldest predicted change.
  always @(negedge clk) begin
    if (upd === 1'b1) begin
      if (exp_q.size() == 0) check("upd_unexpected", 64'(upd), 64'd0);
      else                   check("upd_pos", 64'(pos_flat), 64'(exp_q.pop_front()));
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    rst = 1'b0; tick = 1'b0; btn_up = 1'b0; btn_dn = 1'b0; btn_next = 1'b0;
    model_reset();
    cyc(3);
    rst = 1'b1;
    cyc(1);

    // Reset state.
    check("rst_sel", 64'(sel), 64'd0);
    check("rst_pos", 64'(pos_flat), 64'(model_flat()));
    check("rst_upd", 64'(upd), 64'd0);
    check("rst_at_limit", 64'(at_limit), 64'd0);

    // Single press: one immediate step, visible one cycle later.
    btn_up = 1'b1; model_step(1); cyc(1);
    btn_up = 1'b0;
    check("tap_pos", 64'(pos_flat), 64'(model_flat()));
    check("tap_upd", 64'(upd), 64'd1);
    cyc(2);
    check("tap_upd_clear", 64'(upd), 64'd0);

    // Hold through the delay and three repeat periods.
    btn_up = 1'b1; model_step(1); cyc(1);
    for (int i = 1; i <= 40; i++) begin
      if (i >= 25 && (i - 25) % 5 == 0) model_step(1);
      tick = 1'b1; cyc(1);
      tick = 1'b0; cyc(1);
    end
    btn_up = 1'b0; cyc(2);
    check("hold_pos", 64'(pos_flat), 64'(model_flat()));
    check("hold_pos0", 64'(pos_flat[7:0]), 64'd96);

    // Joint 1 driven to the top limit, then to the bottom limit.
    btn_next = 1'b1; model_next(); cyc(1);
    btn_next = 1'b0;
    check("sel_to_1", 64'(sel), 64'(exp_sel));
    for (int i = 0; i < 90; i++) begin
      if (i == 89) check("below_max_at_limit", 64'(at_limit), 64'd0);
      btn_up = 1'b1; model_step(1); cyc(1);
      btn_up = 1'b0; cyc(1);
    end
    check("max_pos", 64'(pos_flat), 64'(model_flat()));
    check("max_at_limit", 64'(at_limit), 64'd1);
    btn_up = 1'b1; model_step(1); cyc(1);
    btn_up = 1'b0;
    check("max_sat_upd", 64'(upd), 64'd0);
    check("max_sat_pos", 64'(pos_flat), 64'(model_flat()));
    cyc(1);
    for (int i = 0; i < 180; i++) begin
      btn_dn = 1'b1; model_step(0); cyc(1);
      btn_dn = 1'b0; cyc(1);
    end
    check("min_pos", 64'(pos_flat), 64'(model_flat()));
    check("min_at_limit", 64'(at_limit), 64'd1);
    btn_dn = 1'b1; model_step(0); cyc(1);
    btn_dn = 1'b0;
    check("min_sat_upd", 64'(upd), 64'd0);
    cyc(1);

    // Selection wraps through all joints.
    for (int i = 0; i < 4; i++) begin
      btn_next = 1'b1; model_next(); cyc(1);
      btn_next = 1'b0;
      check("sel_cycle", 64'(sel), 64'(exp_sel));
    end

    // btn_next while held: no further steps until released and re-pressed.
    btn_up = 1'b1; model_step(1); cyc(1);
    btn_next = 1'b1; model_next(); cyc(1);
    btn_next = 1'b0;
    tick_n(30);
    check("next_held_pos", 64'(pos_flat), 64'(model_flat()));
    check("next_held_sel", 64'(sel), 64'(exp_sel));
    btn_up = 1'b0; cyc(2);
    btn_up = 1'b1; model_step(1); cyc(1);
    btn_up = 1'b0; cyc(2);
    check("repress_pos", 64'(pos_flat), 64'(model_flat()));

    // Press and btn_next together: step hits the old joint, then sel moves.
    btn_up = 1'b1; btn_next = 1'b1; model_step(1); model_next(); cyc(1);
    btn_up = 1'b0; btn_next = 1'b0; cyc(2);
    check("coincide_pos", 64'(pos_flat), 64'(model_flat()));
    check("coincide_sel", 64'(sel), 64'(exp_sel));

    // Both buttons held: no movement; dropping one gives one immediate step.
    btn_up = 1'b1; btn_dn = 1'b1; cyc(1);
    tick_n(50);
    check("both_pos", 64'(pos_flat), 64'(model_flat()));
    btn_dn = 1'b0; model_step(1); cyc(1);
    check("both_release_pos", 64'(pos_flat), 64'(model_flat()));
    check("both_release_upd", 64'(upd), 64'd1);
    btn_up = 1'b0; cyc(2);

    // Reset in the middle of auto-repeat.
    btn_up = 1'b1; model_step(1); cyc(1);
    for (int i = 1; i <= 32; i++) begin
      if (i >= 25 && (i - 25) % 5 == 0) model_step(1);
      tick = 1'b1; cyc(1);
      tick = 1'b0; cyc(1);
    end
    check("pre_rst_pending", 64'(exp_q.size()), 64'd0);
    check("pre_rst_pos", 64'(pos_flat), 64'(model_flat()));
    rst = 1'b0; #2;
    model_reset();
    exp_q.delete();
    check("async_rst_pos", 64'(pos_flat), 64'(model_flat()));
    check("async_rst_sel", 64'(sel), 64'd0);
    check("async_rst_upd", 64'(upd), 64'd0);
    btn_up = 1'b0; cyc(2);
    rst = 1'b1;
    tick_n(30);
    check("post_rst_idle_pos", 64'(pos_flat), 64'(model_flat()));
    btn_up = 1'b1; model_step(1); cyc(1);
    btn_up = 1'b0;
    check("post_rst_step_pos", 64'(pos_flat), 64'(model_flat()));
    cyc(3);

    check("pending_at_end", 64'(exp_q.size()), 64'd0);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
